barcode_rx: RTL and testbench

- Parametrised serial barcode/station-ID receiver, successor to the fixed 8-bit reader.
- Measures the start-bit low time as the half-period, then samples ID_W data bits MSB-first, one bit per falling edge, half a period after each edge.
- Adds input synchronisation, a configurable validity prefix, a glitch filter, an inter-edge timeout, and error/overrun reporting.
- Sits between the IR sensor input and the digital core.

---
 rtl/barcode_pkg.sv | 17 +
 rtl/bc_sync_edge.sv | 35 +++
 rtl/barcode_rx.sv | 176 +++++++++++++++++
 tb/tb_barcode_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/barcode_pkg.sv
// rtl/barcode_pkg.sv - shared types and constants for the barcode receiver
// Contents:
//   state_t : receiver FSM state encoding
//   TO_MULT : inter-edge timeout length, in measured half-periods
package barcode_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_EDGE = 3'd2,
        SAMPLE    = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam int TO_MULT = 4;

endpackage

// File: rtl/bc_sync_edge.sv
// rtl/bc_sync_edge.sv - two-flop synchroniser with falling-edge detect
// Ports:
//   clk, rst_n : clock, async active-low reset (flops preset to idle-high)
//   bc_i       : raw asynchronous serial line
//   bc_s_o     : synchronised line
//   fall_o     : one-cycle pulse when bc_s_o goes 1 -> 0
module bc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic bc_i,
    output logic bc_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Preset to 1 so that leaving reset never produces a false fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= bc_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign bc_s_o = sync_q;
    assign fall_o = dly_q & ~sync_q;

endmodule

// File: rtl/barcode_rx.sv
// rtl/barcode_rx.sv - parametrised serial barcode / station-ID receiver
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   BC          : async serial data, idle high
//   clr_ID_vld  : core acknowledge, clears ID_vld (a same-cycle set wins)
//   ID_vld      : a valid ID is held in ID
//   ID          : last valid ID
//   frm_err     : one-cycle pulse on framing, prefix or timeout error
//   ovr         : one-cycle pulse when a valid ID overwrites an unacked one
module barcode_rx
    import barcode_pkg::*;
#(
    parameter int ID_W    = 8,
    parameter int CNT_W   = 22,
    parameter int PFX_W   = 2,
    parameter int PFX_VAL = 0,
    parameter int MIN_HP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            BC,
    input  logic            clr_ID_vld,
    output logic            ID_vld,
    output logic [ID_W-1:0] ID,
    output logic            frm_err,
    output logic            ovr
);

    localparam int BIT_W = $clog2(ID_W + 1);

    logic bc_s;
    logic fall;

    bc_sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .bc_i   (BC),
        .bc_s_o (bc_s),
        .fall_o (fall)
    );

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   hp_cnt_q,  hp_cnt_d;
    logic [CNT_W-1:0]   to_cnt_q,  to_cnt_d;
    logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ID_W-1:0]    shreg_q,   shreg_d;
    logic [ID_W-1:0]    id_q,      id_d;
    logic               id_vld_q,  id_vld_d;
    logic               frm_err_q, frm_err_d;
    logic               ovr_q,     ovr_d;

    logic [CNT_W-1:0]   to_limit;
    logic               pfx_ok;

    // Timeout after TO_MULT half-periods with no edge; wraps at CNT_W bits.
    assign to_limit = hp_cnt_q * CNT_W'(TO_MULT);

    generate
        if (PFX_W == 0) begin : g_no_pfx
            assign pfx_ok = 1'b1;
        end else begin : g_pfx
            assign pfx_ok = (shreg_q[ID_W-1 -: PFX_W] == PFX_VAL[PFX_W-1:0]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hp_cnt_q  <= '0;
            to_cnt_q  <= '0;
            smp_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            id_q      <= '0;
            id_vld_q  <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_cnt_q  <= hp_cnt_d;
            to_cnt_q  <= to_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            id_q      <= id_d;
            id_vld_q  <= id_vld_d;
            frm_err_q <= frm_err_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hp_cnt_d  = hp_cnt_q;
        to_cnt_d  = to_cnt_q;
        smp_cnt_d = smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        id_d      = id_q;
        id_vld_d  = id_vld_q;
        frm_err_d = 1'b0;
        ovr_d     = 1'b0;

        // The ack is applied first so that a DONE-set below overrides it.
        if (clr_ID_vld) begin
            id_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    hp_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (!bc_s) begin
                    if (&hp_cnt_q) begin
                        frm_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        hp_cnt_d = hp_cnt_q + 1'b1;
                    end
                end else if (hp_cnt_q < CNT_W'(MIN_HP)) begin
                    state_d = IDLE;
                end else begin
                    to_cnt_d = '0;
                    state_d  = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (fall) begin
                    smp_cnt_d = '0;
                    state_d   = SAMPLE;
                end else if (to_cnt_q == to_limit) begin
                    frm_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            SAMPLE: begin
                // Falls seen here are ignored; the bit is taken mid-period.
                smp_cnt_d = smp_cnt_q + 1'b1;
                if (smp_cnt_q == hp_cnt_q) begin
                    shreg_d   = {shreg_q[ID_W-2:0], bc_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(ID_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        to_cnt_d = '0;
                        state_d  = WAIT_EDGE;
                    end
                end
            end
            DONE: begin
                if (pfx_ok) begin
                    id_d     = shreg_q;
                    id_vld_d = 1'b1;
                    ovr_d    = id_vld_q;
                end else begin
                    frm_err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ID_vld  = id_vld_q;
    assign ID      = id_q;
    assign frm_err = frm_err_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_barcode_rx.sv
// tb/tb_barcode_rx.sv - self-checking randomized bench for barcode_rx
module tb_barcode_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bc = 1'b1;
    logic        bc12 = 1'b1;
    logic        clr = 1'b0;
    logic        clr12 = 1'b0;
    logic        vld, vld12, frm, frm12, ovr, ovr12;
    logic [7:0]  id;
    logic [11:0] id12;

    int checks = 0;
    int failures = 0;
    int frm_seen = 0;
    int ovr_seen = 0;
    int both_seen = 0;
    int frm12_seen = 0;
    int cyc = 0;

    // Reference model state (8-bit receiver, prefix 2'b00)
    logic [7:0] m_id = 8'h00;
    logic       m_vld = 1'b0;
    int         m_frm = 0;
    int         m_ovr = 0;

    always #5 clk = ~clk;

    barcode_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .BC         (bc),
        .clr_ID_vld (clr),
        .ID_vld     (vld),
        .ID         (id),
        .frm_err    (frm),
        .ovr        (ovr)
    );

    barcode_rx #(.ID_W(12), .PFX_W(0)) dut12 (
        .clk        (clk),
        .rst_n      (rst_n),
        .BC         (bc12),
        .clr_ID_vld (clr12),
        .ID_vld     (vld12),
        .ID         (id12),
        .frm_err    (frm12),
        .ovr        (ovr12)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frm)         frm_seen   <= frm_seen + 1;
        if (ovr)         ovr_seen   <= ovr_seen + 1;
        if (frm && ovr)  both_seen  <= both_seen + 1;
        if (frm12)       frm12_seen <= frm12_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input int which, input logic v, input int n);
        if (which == 0) bc = v; else bc12 = v;
        repeat (n) @(negedge clk);
    endtask

    // Start bit: low p, high p. Each data bit is a 2p period opening with a
    // fall; a '1' returns high after p/2, a '0' stays low until 3p/2.
    task automatic send(input int which, input logic [15:0] v, input int nbits,
                        input int nsend, input int p);
        hold(which, 1'b0, p);
        hold(which, 1'b1, p);
        for (int i = 0; i < nsend; i++) begin
            if (v[nbits-1-i]) begin
                hold(which, 1'b0, p / 2);
                hold(which, 1'b1, 2 * p - p / 2);
            end else begin
                hold(which, 1'b0, p + p / 2);
                hold(which, 1'b1, p - p / 2);
            end
        end
    endtask

    function automatic void model_frame(input logic [7:0] v);
        if ((v >> 6) == 0) begin
            if (m_vld) m_ovr++;
            m_id  = v;
            m_vld = 1'b1;
        end else begin
            m_frm++;
        end
    endfunction

    task automatic frame_check(input string tag);
        idle(2);
        check({tag, "_id"},  32'(id),  32'(m_id));
        check({tag, "_vld"}, 32'(vld), 32'(m_vld));
        check({tag, "_frm"}, frm_seen, m_frm);
        check({tag, "_ovr"}, ovr_seen, m_ovr);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_vld = 1'b0;
        idle(2);
    endtask

    initial begin
        logic [7:0] v;
        int p, t0, tf, hit;

        idle(5);
        rst_n = 1'b1;
        idle(3);
        check("rst_id",   32'(id),   32'h0);
        check("rst_vld",  32'(vld),  32'h0);
        check("rst_frm",  32'(frm),  32'h0);
        check("rst_ovr",  32'(ovr),  32'h0);
        check("rst_id12", 32'(id12), 32'h0);

        send(0, 16'h25, 8, 8, 50); idle(6);
        model_frame(8'h25); frame_check("nominal");

        send(0, 16'hC5, 8, 8, 30); idle(6);
        model_frame(8'hC5); frame_check("prefix");

        pulse_clr();
        check("clr1_vld", 32'(vld), 32'h0);
        check("clr1_id",  32'(id),  32'h25);
        send(0, 16'h11, 8, 8, 20); idle(6); model_frame(8'h11); frame_check("ow1");
        send(0, 16'h22, 8, 8, 20); idle(6); model_frame(8'h22); frame_check("ow2");
        pulse_clr();
        check("ack_vld", 32'(vld), 32'h0);
        check("ack_id",  32'(id),  32'h22);

        // Timeout after 3 bits, line then held high
        p = 50;
        send(0, 16'hFF, 8, 3, p);
        t0 = cyc;
        tf = t0 - 2 * p;
        hit = 0;
        for (int i = 0; i < 8 * p; i++) begin
            @(negedge clk);
            if (frm) begin
                hit = cyc;
                break;
            end
        end
        check("to_window", 32'((hit >= tf + 4 * p) && (hit <= tf + 6 * p)), 32'h1);
        m_frm++;
        idle(10);
        frame_check("timeout");

        hold(0, 1'b0, 2);
        hold(0, 1'b1, 30);
        frame_check("glitch");
        send(0, 16'h3A, 8, 8, 20); idle(6); model_frame(8'h3A); frame_check("post_to");

        for (int k = 0; k < 10; k++) begin
            p = $urandom_range(30, 6);
            v = 8'($urandom);
            if ($urandom_range(1, 0) == 1) v = v & 8'h3F;
            if ($urandom_range(2, 0) == 0) pulse_clr();
            send(0, {8'h00, v}, 8, 8, p);
            idle(5);
            model_frame(v);
            frame_check($sformatf("rnd%0d_%02h", k, v));
        end

        send(1, 16'h0ABC, 12, 12, 10); idle(6);
        check("w12_id",  32'(id12), 32'hABC);
        check("w12_vld", 32'(vld12), 32'h1);
        check("w12_frm", frm12_seen, 0);

        // Ack coincident with the DONE cycle: set must win
        pulse_clr();
        hit = 0;
        fork
            send(0, 16'h1C, 8, 8, 16);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (dut.state_q == barcode_pkg::DONE) begin
                        clr = 1'b1;
                        @(negedge clk);
                        clr = 1'b0;
                        hit = 1;
                        break;
                    end
                end
            end
        join
        check("coll_seen", 32'(hit), 32'h1);
        idle(4);
        model_frame(8'h1C);
        frame_check("coll");

        // Reset in the middle of bit 5
        send(0, 16'hA5, 8, 4, 20);
        bc = 1'b0;
        idle(5);
        rst_n = 1'b0;
        #1;
        check("mrst_id",  32'(id),  32'h0);
        check("mrst_vld", 32'(vld), 32'h0);
        check("mrst_frm", 32'(frm), 32'h0);
        check("mrst_ovr", 32'(ovr), 32'h0);
        m_id  = 8'h00;
        m_vld = 1'b0;
        bc = 1'b1;
        idle(4);
        rst_n = 1'b1;
        idle(4);
        send(0, 16'h07, 8, 8, 25); idle(6); model_frame(8'h07); frame_check("post_rst");

        check("frm_ovr_excl", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
